// File: rtl/pipe_stage_chain.sv
// Chain of DEPTH valid/ready register stages. Bubbles compress forward,
// flush clears every valid bit, and DEPTH=0 collapses to a wire.
module pipe_stage_chain #(
  parameter int               WIDTH     = 18,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       occupancy
);

  // Handshake: a beat moves when valid && ready on a rising clk edge; valid
  // never waits for ready, and ready is combinational back through the chain.

  if (DEPTH == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = clk ^ rst_n;

    assign out_data  = in_data;
    assign out_valid = in_valid && !flush;
    assign in_ready  = out_ready && !flush;
    assign occupancy = 5'd0;
  end else begin : g_chain
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] d [DEPTH];
    logic [4:0]       cnt;

    // Advance is resolved from the tail backward so a full chain can move
    // every stage in the same cycle the tail drains.
    always_comb begin
      adv            = '0;
      adv[DEPTH-1]   = v[DEPTH-1] && out_ready && !flush;
      for (int i = DEPTH - 2; i >= 0; i--) begin
        adv[i] = v[i] && (!v[i+1] || adv[i+1]);
      end
    end

    assign in_ready  = !flush && (!v[0] || adv[0]);
    assign out_valid = v[DEPTH-1] && !flush;
    assign out_data  = d[DEPTH-1];

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      logic             ld;
      logic [WIDTH-1:0] src;

      if (g == 0) begin : g_head
        assign ld  = in_valid && in_ready;
        assign src = in_data;
      end else begin : g_body
        assign ld  = adv[g-1];
        assign src = d[g-1];
      end

      // Flush drops valid bits only; data registers keep their contents.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v[g] <= 1'b0;
          d[g] <= RST_VALUE;
        end else if (flush) begin
          v[g] <= 1'b0;
        end else if (ld) begin
          v[g] <= 1'b1;
          d[g] <= src;
        end else if (adv[g]) begin
          v[g] <= 1'b0;
        end
      end
    end

    always_comb begin
      cnt = 5'd0;
      for (int i = 0; i < DEPTH; i++) begin
        cnt = cnt + {4'd0, v[i]};
      end
    end

    assign occupancy = cnt;
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain across DEPTH 0/2/3/4; a monitor pops
// the expected queue whenever the selected instance transfers an output.
module tb_pipe_stage_chain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [17:0] in_data = '0;
  int          sel = 3;

  int          total = 0;
  int          bad = 0;
  logic [17:0] exp_q[$];
  logic [17:0] mon_exp;

  always #5 clk = ~clk;

  logic        ir0, ir2, ir3, ir4, ov0, ov2, ov3, ov4;
  logic [17:0] od0, od2, od3, od4;
  logic [4:0]  oc0, oc2, oc3, oc4;
  logic        s_ir, s_ov;
  logic [17:0] s_od;
  logic [4:0]  s_occ;

  pipe_stage_chain #(.WIDTH(18), .DEPTH(0)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid && sel == 0),
    .in_ready(ir0), .in_data(in_data), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .occupancy(oc0));

  pipe_stage_chain #(.WIDTH(18), .DEPTH(2), .RST_VALUE(18'h3FFFF)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid && sel == 2),
    .in_ready(ir2), .in_data(in_data), .out_valid(ov2), .out_ready(out_ready),
    .out_data(od2), .occupancy(oc2));

  pipe_stage_chain #(.WIDTH(18), .DEPTH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid && sel == 3),
    .in_ready(ir3), .in_data(in_data), .out_valid(ov3), .out_ready(out_ready),
    .out_data(od3), .occupancy(oc3));

  pipe_stage_chain #(.WIDTH(18), .DEPTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid && sel == 4),
    .in_ready(ir4), .in_data(in_data), .out_valid(ov4), .out_ready(out_ready),
    .out_data(od4), .occupancy(oc4));

  always_comb begin
    case (sel)
      0:       begin s_ir = ir0; s_ov = ov0; s_od = od0; s_occ = oc0; end
      2:       begin s_ir = ir2; s_ov = ov2; s_od = od2; s_occ = oc2; end
      4:       begin s_ir = ir4; s_ov = ov4; s_od = od4; s_occ = oc4; end
      default: begin s_ir = ir3; s_ov = ov3; s_od = od3; s_occ = oc3; end
    endcase
  end

  // Monitor: every output transfer of the selected instance is scored.
  always @(negedge clk) begin
    if (s_ov && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got %0h want nothing", s_od);
      end else begin
        mon_exp = exp_q.pop_front();
        if (s_od !== mon_exp) begin
          bad++;
          $display("FAIL out_data: got %0h want %0h", s_od, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  logic [3:0] f_or = 4'b1101;
  logic [3:0] f_fl = 4'b1000;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ov3, 0);
    chk("rst_occ", oc3, 0);
    chk("rst_out_data", od3, 18'h0);
    chk("rst_in_ready", ir3, 1);
    chk("rst_out_data_d2", od2, 18'h3FFFF);
    rst_n = 1'b1;

    // Back-to-back stream through DEPTH=3
    sel = 3;
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      in_valid = (k < 4);
      in_data  = 18'(k + 1);
      if (k < 4) exp_q.push_back(in_data);
      @(negedge clk);
      if (k < 4) chk("a_in_ready", s_ir, 1);
      chk("a_out_valid", s_ov, (k >= 3) ? 1 : 0);
    end
    drain("a_drain");

    // Fill while stalled, then release
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      in_valid = 1'b1;
      in_data  = 18'(10 * (k + 1));
      exp_q.push_back(in_data);
      @(negedge clk);
      chk("b_in_ready", s_ir, 1);
    end
    tick();
    in_data = 18'd40;
    @(negedge clk);
    chk("b_full_in_ready", s_ir, 0);
    chk("b_full_occ", s_occ, 3);
    chk("b_head_data", s_od, 18'd10);
    for (int k = 0; k < 5; k++) begin
      tick();
      out_ready = 1'b1;
      in_valid  = (k < 2);
      in_data   = (k == 0) ? 18'd40 : 18'd50;
      if (k < 2) exp_q.push_back(in_data);
      @(negedge clk);
      chk("b_out_valid", s_ov, 1);
      if (k < 2) chk("b_in_ready_rel", s_ir, 1);
    end
    tick();
    in_valid = 1'b0;
    drain("b_drain");
    chk("b_occ_empty", s_occ, 0);

    // Bubble compression in DEPTH=4
    tick();
    sel = 4;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 18'd7;
    exp_q.push_back(in_data);
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data = 18'd8;
    exp_q.push_back(in_data);
    @(negedge clk);
    chk("c_in_ready", s_ir, 1);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("c_occ", s_occ, 2);
    chk("c_out_valid", s_ov, 1);
    chk("c_head_data", s_od, 18'd7);
    tick();
    out_ready = 1'b1;
    drain("c_drain");

    // Flush with a simultaneous input in DEPTH=2
    tick();
    sel = 2;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 18'd100;
    tick();
    in_data = 18'd200;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("d_occ_full", s_occ, 2);
    tick();
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 18'd9;
    @(negedge clk);
    chk("d_flush_out_valid", s_ov, 0);
    chk("d_flush_in_ready", s_ir, 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("d_occ_after", s_occ, 0);
    chk("d_out_valid_after", s_ov, 0);
    tick();
    out_ready = 1'b1;
    repeat (4) tick();
    in_valid = 1'b1;
    in_data = 18'd11;
    exp_q.push_back(in_data);
    tick();
    in_valid = 1'b0;
    drain("d_drain");

    // Asynchronous reset while full
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 18'h123;
    tick();
    in_data = 18'h456;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("e_occ_full", s_occ, 2);
    rst_n = 1'b0;
    #1;
    chk("e_out_valid", s_ov, 0);
    chk("e_occ", s_occ, 0);
    chk("e_out_data", s_od, 18'h3FFFF);
    chk("e_in_ready", s_ir, 1);
    @(posedge clk);
    #2;
    chk("e_occ_hold", s_occ, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 18'd33;
    exp_q.push_back(in_data);
    tick();
    in_valid = 1'b0;
    drain("e_drain");

    // Combinational bypass
    for (int k = 0; k < 4; k++) begin
      tick();
      sel = 0;
      out_ready = f_or[k];
      flush = f_fl[k];
      in_valid = 1'b1;
      in_data = 18'h155;
      if (f_or[k] && !f_fl[k]) exp_q.push_back(in_data);
      #1;
      chk("f_out_data", s_od, 18'h155);
      chk("f_out_valid", s_ov, f_fl[k] ? 0 : 1);
      chk("f_in_ready", s_ir, (f_or[k] && !f_fl[k]) ? 1 : 0);
      chk("f_occ", s_occ, 0);
    end
    tick();
    in_valid = 1'b0;
    flush = 1'b0;
    drain("f_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
